icache: RTL and testbench



---
 rtl/icache_pkg.sv | 14 +
 rtl/icache_line_store.sv | 45 ++++
 rtl/icache.sv | 107 ++++++++++
 tb/tb_icache.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IC_IDLE  = 1'b0,
    IC_FETCH = 1'b1
  } ic_state_e;

  localparam int IC_LINES     = 128;
  localparam int IC_ADDR_BITS = 17;
  localparam int IC_IDX_W     = $clog2(IC_LINES);
  localparam int IC_TAG_W     = IC_ADDR_BITS - IC_IDX_W - 2;

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the instruction cache: one async read port, one write port.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int LINES = IC_LINES,
  parameter int IDX_W = IC_IDX_W,
  parameter int TAG_W = IC_TAG_W
) (
  input  logic             clk_in,
  input  logic             clr,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  always_ff @(posedge clk_in) begin
    if (clr) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tags and data carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk_in) begin
    if (we && !clr) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between IF and memCtrl.
// Hits answer in one cycle; misses hold a memCtrl fetch until it returns.
module icache
  import icache_pkg::*;
#(
  parameter int LINES     = IC_LINES,
  parameter int ADDR_BITS = IC_ADDR_BITS
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        IF_req_in,
  input  logic [31:0] IF_addr_in,
  input  logic        flush_in,
  output logic        IF_instE_out,
  output logic [31:0] IF_inst_out,
  output logic        memCtrl_req_out,
  output logic [31:0] memCtrl_addr_out,
  input  logic        memCtrl_instE_in,
  input  logic [31:0] memCtrl_inst_in
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_BITS - IDX_W - 2;

  ic_state_e state;
  logic      drop;

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] req_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             fill_we;
  logic             accept;
  logic             hit;
  logic             unused_addr_lsb;

  assign rd_idx          = IF_addr_in[IDX_W+1:2];
  assign req_tag         = IF_addr_in[ADDR_BITS-1:IDX_W+2];
  assign unused_addr_lsb = ^IF_addr_in[1:0];

  // The response cycle blocks acceptance so IF has advanced its PC before the next lookup.
  assign accept  = IF_req_in && !flush_in && !IF_instE_out;
  assign hit     = rd_valid && (rd_tag == req_tag);
  assign fill_we = rdy_in && (state == IC_FETCH) && memCtrl_instE_in;

  icache_line_store #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_line_store (
    .clk_in   (clk_in),
    .clr      (rst_in),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill_we),
    .wr_idx   (memCtrl_addr_out[IDX_W+1:2]),
    .wr_tag   (memCtrl_addr_out[ADDR_BITS-1:IDX_W+2]),
    .wr_data  (memCtrl_inst_in)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= IC_IDLE;
      drop             <= 1'b0;
      IF_instE_out     <= 1'b0;
      IF_inst_out      <= '0;
      memCtrl_req_out  <= 1'b0;
      memCtrl_addr_out <= '0;
    end else if (rdy_in) begin
      IF_instE_out <= 1'b0;
      case (state)
        IC_IDLE: begin
          if (accept) begin
            if (hit) begin
              IF_inst_out  <= rd_data;
              IF_instE_out <= 1'b1;
            end else begin
              memCtrl_req_out  <= 1'b1;
              memCtrl_addr_out <= {IF_addr_in[31:2], 2'b00};
              drop             <= 1'b0;
              state            <= IC_FETCH;
            end
          end
        end
        IC_FETCH: begin
          // memCtrl cannot abort, so a flush only suppresses the IF response.
          if (flush_in) begin
            drop <= 1'b1;
          end
          if (memCtrl_instE_in) begin
            memCtrl_req_out <= 1'b0;
            state           <= IC_IDLE;
            if (!drop && !flush_in) begin
              IF_inst_out  <= memCtrl_inst_in;
              IF_instE_out <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomized scoreboard bench for icache with a behavioural memCtrl and cache model.
module tb_icache;

  localparam int LINES = 128;
  localparam int ABITS = 17;
  localparam int IDX_W = 7;
  localparam int TAG_W = ABITS - IDX_W - 2;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        IF_req_in;
  logic [31:0] IF_addr_in;
  logic        flush_in;
  logic        IF_instE_out;
  logic [31:0] IF_inst_out;
  logic        memCtrl_req_out;
  logic [31:0] memCtrl_addr_out;
  logic        memCtrl_instE_in;
  logic [31:0] memCtrl_inst_in;

  int checks = 0;
  int failures = 0;
  int fills = 0;
  int extra_lat = 0;

  bit          ref_valid [LINES];
  int unsigned ref_tag   [LINES];
  logic [31:0] exp_q[$];

  icache dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .rdy_in           (rdy_in),
    .IF_req_in        (IF_req_in),
    .IF_addr_in       (IF_addr_in),
    .flush_in         (flush_in),
    .IF_instE_out     (IF_instE_out),
    .IF_inst_out      (IF_inst_out),
    .memCtrl_req_out  (memCtrl_req_out),
    .memCtrl_addr_out (memCtrl_addr_out),
    .memCtrl_instE_in (memCtrl_instE_in),
    .memCtrl_inst_in  (memCtrl_inst_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // RAM only decodes ABITS address bits, so aliases return the same word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] m;
    m = a % 32'h20000;
    if (m == 0) return 32'h00000013;
    return (m * 32'h9E3779B1) ^ 32'h5A5A0003;
  endfunction

  function automatic int ref_idx(input logic [31:0] a);
    return int'((a / 4) % LINES);
  endfunction

  function automatic int unsigned ref_tagof(input logic [31:0] a);
    return (a / (4 * LINES)) % (1 << TAG_W);
  endfunction

  function automatic bit ref_hit(input logic [31:0] a);
    return ref_valid[ref_idx(a)] && (ref_tag[ref_idx(a)] == ref_tagof(a));
  endfunction

  // memCtrl model: fixed 6-cycle service plus extra_lat contention, then one spurious pulse.
  initial begin
    bit          busy = 0;
    bit          spur = 0;
    bit          stable = 1;
    bit          rst_seen;
    int          cnt = 0;
    logic [31:0] a = '0;
    memCtrl_instE_in = 1'b0;
    memCtrl_inst_in  = '0;
    forever begin
      @(posedge clk_in);
      rst_seen = rst_in;
      @(negedge clk_in);
      memCtrl_instE_in = 1'b0;
      if (rst_seen) begin
        busy = 0;
        spur = 0;
      end else if (spur) begin
        spur = 0;
        chk("req_fall", memCtrl_req_out, 0);
        memCtrl_inst_in  = ~memCtrl_inst_in;
        memCtrl_instE_in = 1'b1;
      end else if (busy) begin
        if (!memCtrl_req_out || memCtrl_addr_out !== a) stable = 0;
        cnt--;
        if (cnt == 0) begin
          chk("req_stable", stable, 1);
          memCtrl_inst_in  = mem_word(a);
          memCtrl_instE_in = 1'b1;
          busy = 0;
          spur = 1;
          fills++;
        end
      end else if (memCtrl_req_out) begin
        a = memCtrl_addr_out;
        busy = 1;
        stable = 1;
        cnt = 5 + extra_lat;
      end
    end
  end

  // Monitor: every fresh IF pulse must match the oldest expected instruction.
  initial begin
    bit rdy_prev;
    logic [31:0] e;
    forever begin
      @(posedge clk_in);
      rdy_prev = rdy_in;
      @(negedge clk_in);
      if (IF_instE_out && rdy_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual=%h expected=none t=%0t", IF_inst_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("if_inst", IF_inst_out, e);
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] addr, input int flush_after, input bit keep);
    bit          exp_hit;
    bit          blocked;
    bit          seen_req = 0;
    bit          got = 0;
    int          n = 0;
    int          f0;
    logic [31:0] req_addr = '0;
    exp_hit = ref_hit(addr);
    blocked = IF_instE_out;
    ref_valid[ref_idx(addr)] = 1;
    ref_tag[ref_idx(addr)]   = ref_tagof(addr);
    IF_req_in  = 1'b1;
    IF_addr_in = addr;
    if (flush_after < 0) begin
      exp_q.push_back(mem_word(addr));
      while (!got && n < 300) begin
        @(negedge clk_in);
        n++;
        if (memCtrl_req_out && !seen_req) begin
          seen_req = 1;
          req_addr = memCtrl_addr_out;
        end
        if (IF_instE_out) got = 1;
      end
      chk("response_seen", got, 1);
      if (exp_hit) begin
        chk("hit_latency", n, blocked ? 2 : 1);
        chk("hit_no_mem", seen_req, 0);
      end else begin
        chk("miss_req", seen_req, 1);
        chk("miss_addr", req_addr, addr);
      end
      if (!keep) IF_req_in = 1'b0;
    end else begin
      f0 = fills;
      while (!memCtrl_req_out && n < 20) begin
        @(negedge clk_in);
        n++;
      end
      chk("flush_miss_req", memCtrl_req_out, 1);
      IF_req_in = 1'b0;
      repeat (flush_after) @(negedge clk_in);
      flush_in = 1'b1;
      @(negedge clk_in);
      flush_in = 1'b0;
      n = 0;
      while (fills == f0 && n < 300) begin
        @(negedge clk_in);
        n++;
      end
      chk("flush_fill_done", fills != f0, 1);
      repeat (2) @(negedge clk_in);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    int n;
    rst_in     = 1'b1;
    rdy_in     = 1'b1;
    IF_req_in  = 1'b0;
    IF_addr_in = '0;
    flush_in   = 1'b0;
    for (int i = 0; i < LINES; i++) ref_valid[i] = 0;
    repeat (3) @(negedge clk_in);
    chk("rst_instE", IF_instE_out, 0);
    chk("rst_inst", IF_inst_out, 0);
    chk("rst_req", memCtrl_req_out, 0);
    chk("rst_addr", memCtrl_addr_out, 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // cold miss, hit, back-to-back hits
    do_fetch(32'h0, -1, 0);
    do_fetch(32'h0, -1, 0);
    do_fetch(32'h0, -1, 1);
    do_fetch(32'h0, -1, 0);
    // index conflict
    do_fetch(32'h200, -1, 0);
    do_fetch(32'h200, -1, 0);
    do_fetch(32'h0, -1, 0);
    // long MEM contention
    extra_lat = 10;
    do_fetch(32'h1004, -1, 0);
    extra_lat = 0;
    // flush mid-miss, flush coincident with memCtrl response
    do_fetch(32'h40, 2, 0);
    do_fetch(32'h40, -1, 0);
    do_fetch(32'h80, 5, 0);
    do_fetch(32'h80, -1, 0);
    // rdy_in low holds the pulse without repeating it
    do_fetch(32'h80, -1, 0);
    rdy_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      chk("rdy_hold", IF_instE_out, 1);
    end
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("rdy_release", IF_instE_out, 0);

    for (int i = 0; i < 80; i++) begin
      addr = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 2) << 9) | ($urandom_range(0, 1) << 20);
      extra_lat = $urandom_range(0, 3);
      if (!ref_hit(addr) && $urandom_range(0, 4) == 0)
        do_fetch(addr, $urandom_range(0, 5), 0);
      else
        do_fetch(addr, -1, $urandom_range(0, 1));
    end
    IF_req_in = 1'b0;
    extra_lat = 0;
    repeat (3) @(negedge clk_in);

    // reset during the third byte cycle of a miss
    IF_req_in  = 1'b1;
    IF_addr_in = 32'h1FFFC;
    n = 0;
    while (!memCtrl_req_out && n < 20) begin
      @(negedge clk_in);
      n++;
    end
    chk("rst_fetch_req", memCtrl_req_out, 1);
    IF_req_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < LINES; i++) ref_valid[i] = 0;
    chk("midrst_req", memCtrl_req_out, 0);
    chk("midrst_instE", IF_instE_out, 0);
    chk("midrst_addr", memCtrl_addr_out, 0);
    repeat (8) @(negedge clk_in);
    chk("midrst_no_pulse", exp_q.size(), 0);
    do_fetch(32'h0, -1, 0);
    do_fetch(32'h1FFFC, -1, 0);
    do_fetch(32'h1FFFC, -1, 0);

    repeat (4) @(negedge clk_in);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
